up_counter_mod: RTL and testbench

- Parameterised modulo up-counter with prescaler, synchronous load/clear, terminal-count pulse and wrap accounting.
- Counts in the opposite direction to the team's existing 3-bit down counter and shares its clk/reset convention.
- Used as a timebase and event counter.
- Cascadable: one instance's tc drives the next instance's en.

---
 rtl/up_counter_mod.sv | 72 +++++++
 tb/tb_up_counter_mod.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/up_counter_mod.sv
// Modulo up-counter with prescaler, synchronous clear/load, terminal-count pulse
// and saturating wrap count with sticky overflow. Cascade by feeding tc into en.
module up_counter_mod #(
    parameter int WIDTH    = 3,
    parameter int MOD_MAX  = 7,
    parameter int PRESCALE = 1,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic [WRAP_W-1:0] wraps,
    output logic              overflow
);

    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MOD_MAX);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc;
    logic [WIDTH-1:0] load_clamped;
    logic             step;

    always_comb begin
        load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
        step         = en && (psc == PSC_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            psc      <= '0;
            tc       <= 1'b0;
            wraps    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            count    <= '0;
            psc      <= '0;
            tc       <= 1'b0;
            wraps    <= '0;
            overflow <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            psc   <= '0;
            tc    <= 1'b0;
        end else if (step) begin
            psc <= '0;
            if (count == MAX_V) begin
                count <= '0;
                tc    <= 1'b1;
                // wraps saturates; the wrap that would exceed it sets overflow instead
                if (wraps != '1)
                    wraps <= wraps + 1'b1;
                else
                    overflow <= 1'b1;
            end else begin
                count <= count + 1'b1;
                tc    <= 1'b0;
            end
        end else begin
            if (en)
                psc <= psc + 1'b1;
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_up_counter_mod.sv
// Directed bench for up_counter_mod: default, prescaled and small-wrap-width
// instances, each driven by its own inputs from a single linear sequence.
module tb_up_counter_mod;

    logic clk;
    int   tests;
    int   fails;

    // u0: defaults (WIDTH 3, MOD_MAX 7, PRESCALE 1, WRAP_W 8)
    logic       rst0, en0, clr0, load0, tc0, ovf0;
    logic [2:0] lv0, cnt0;
    logic [7:0] wr0;
    // u1: MOD_MAX 4, PRESCALE 3
    logic       rst1, en1, clr1, load1, tc1, ovf1;
    logic [2:0] lv1, cnt1;
    logic [7:0] wr1;
    // u2: MOD_MAX 1, WRAP_W 2
    logic       rst2, en2, clr2, load2, tc2, ovf2;
    logic [2:0] lv2, cnt2;
    logic [1:0] wr2;

    up_counter_mod u0 (
        .clk(clk), .reset(rst0), .en(en0), .clr(clr0), .load(load0), .load_val(lv0),
        .count(cnt0), .tc(tc0), .wraps(wr0), .overflow(ovf0)
    );

    up_counter_mod #(.WIDTH(3), .MOD_MAX(4), .PRESCALE(3), .WRAP_W(8)) u1 (
        .clk(clk), .reset(rst1), .en(en1), .clr(clr1), .load(load1), .load_val(lv1),
        .count(cnt1), .tc(tc1), .wraps(wr1), .overflow(ovf1)
    );

    up_counter_mod #(.WIDTH(3), .MOD_MAX(1), .PRESCALE(1), .WRAP_W(2)) u2 (
        .clk(clk), .reset(rst2), .en(en2), .clr(clr2), .load(load2), .load_val(lv2),
        .count(cnt2), .tc(tc2), .wraps(wr2), .overflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        {rst0, rst1, rst2} = 3'b111;
        {en0, clr0, load0, en1, clr1, load1, en2, clr2, load2} = '0;
        lv0 = '0; lv1 = '0; lv2 = '0;

        #2;
        chk("rst_count0", 32'(cnt0), 0);
        chk("rst_tc0", 32'(tc0), 0);
        chk("rst_wraps0", 32'(wr0), 0);
        chk("rst_ovf0", 32'(ovf0), 0);
        chk("rst_count1", 32'(cnt1), 0);
        chk("rst_wraps2", 32'(wr2), 0);

        #8;  // t=10: release reset between edges, enable u0
        {rst0, rst1, rst2} = 3'b000;
        en0 = 1'b1;

        // u0 free-running: 0..7 then wrap, twice
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("run_count0", 32'(cnt0), 32'(k % 8));
            chk("run_tc0", 32'(tc0), (k % 8 == 0) ? 1 : 0);
            chk("run_wraps0", 32'(wr0), 32'(k / 8));
            chk("run_ovf0", 32'(ovf0), 0);
        end

        // hold
        en0 = 1'b0;
        tick();
        chk("hold_count0", 32'(cnt0), 0);
        chk("hold_tc0", 32'(tc0), 0);
        tick();
        chk("hold2_count0", 32'(cnt0), 0);

        // load 5, then continue counting
        en0 = 1'b1; load0 = 1'b1; lv0 = 3'd5;
        tick();
        chk("load_count0", 32'(cnt0), 5);
        load0 = 1'b0;
        tick();
        chk("after_load0", 32'(cnt0), 6);
        tick();
        chk("at_max0", 32'(cnt0), 7);

        // load while wrap pending: load wins
        load0 = 1'b1; lv0 = 3'd2;
        tick();
        chk("ldwrap_count0", 32'(cnt0), 2);
        chk("ldwrap_tc0", 32'(tc0), 0);
        chk("ldwrap_wraps0", 32'(wr0), 2);
        load0 = 1'b0;
        repeat (5) tick();
        chk("pre_clr_count0", 32'(cnt0), 7);

        // clr + load at MOD_MAX: clr wins
        clr0 = 1'b1; load0 = 1'b1; lv0 = 3'd3;
        tick();
        chk("clr_count0", 32'(cnt0), 0);
        chk("clr_wraps0", 32'(wr0), 0);
        chk("clr_tc0", 32'(tc0), 0);
        chk("clr_ovf0", 32'(ovf0), 0);
        clr0 = 1'b0; load0 = 1'b0;

        // count to 6 with one wrap behind it, then async reset mid-cycle
        repeat (14) tick();
        chk("pre_rst_count0", 32'(cnt0), 6);
        chk("pre_rst_wraps0", 32'(wr0), 1);
        #3;
        rst0 = 1'b1;
        #1;
        chk("arst_count0", 32'(cnt0), 0);
        chk("arst_wraps0", 32'(wr0), 0);
        chk("arst_tc0", 32'(tc0), 0);
        chk("arst_ovf0", 32'(ovf0), 0);
        #10;
        chk("arst_hold_count0", 32'(cnt0), 0);
        rst0 = 1'b0;
        tick();
        chk("post_rst_count0", 32'(cnt0), 1);
        en0 = 1'b0;

        // u1: prescale 3, modulo 5 -> one wrap every 15 edges
        en1 = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("psc_count1", 32'(cnt1), 32'((k / 3) % 5));
            chk("psc_tc1", 32'(tc1), (k == 15) ? 1 : 0);
        end
        chk("psc_wraps1", 32'(wr1), 1);
        tick();
        chk("psc16_count1", 32'(cnt1), 0);
        chk("psc16_tc1", 32'(tc1), 0);

        // freeze for 5 cycles, psc sits at 1
        en1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("frz_count1", 32'(cnt1), 0);
        end
        en1 = 1'b1;
        tick();
        chk("unfrz1_count1", 32'(cnt1), 0);
        tick();
        chk("unfrz2_count1", 32'(cnt1), 1);

        // clamped load, prescaler restarts
        load1 = 1'b1; lv1 = 3'd7;
        tick();
        chk("clamp_count1", 32'(cnt1), 4);
        load1 = 1'b0;
        tick();
        tick();
        chk("clamp_psc_count1", 32'(cnt1), 4);
        tick();
        chk("clamp_wrap_count1", 32'(cnt1), 0);
        chk("clamp_wrap_tc1", 32'(tc1), 1);
        chk("clamp_wrap_wraps1", 32'(wr1), 2);
        en1 = 1'b0;

        // u2: 2-bit wrap counter saturates at 3, then overflow
        en2 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("sat_count2", 32'(cnt2), 32'(k % 2));
            chk("sat_tc2", 32'(tc2), (k % 2 == 0) ? 1 : 0);
            chk("sat_wraps2", 32'(wr2), (k / 2 > 3) ? 3 : 32'(k / 2));
            chk("sat_ovf2", 32'(ovf2), (k >= 8) ? 1 : 0);
        end
        en2 = 1'b0;
        repeat (3) tick();
        chk("ovf_sticky2", 32'(ovf2), 1);
        chk("wraps_sticky2", 32'(wr2), 3);
        clr2 = 1'b1;
        tick();
        chk("clr_ovf2", 32'(ovf2), 0);
        chk("clr_wraps2", 32'(wr2), 0);
        clr2 = 1'b0;
        tick();
        chk("post_clr_ovf2", 32'(ovf2), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
